// File: rtl/fifo16_8bit.sv
// 16 x 8-bit synchronous FIFO with a global enable and active-low full/empty flags.
// Reads return registered data; overflow and underflow requests are dropped without effect.
module fifo16_8bit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             RD,
    input  logic             WR,
    input  logic [WIDTH-1:0] dataIN,
    output logic [WIDTH-1:0] dataOUT,
    output logic             FULL_n,
    output logic             EMPTY_n
);

    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             wr_ok_c;
    logic             rd_ok_c;

    // Both requests are judged against the occupancy before the edge.
    assign wr_ok_c = en & WR & (count != CNT_FULL);
    assign rd_ok_c = en & RD & (count != '0);

    always_comb begin
        count_next = count;
        if (wr_ok_c && !rd_ok_c) begin
            count_next = count + CNT_ONE;
        end else if (rd_ok_c && !wr_ok_c) begin
            count_next = count - CNT_ONE;
        end
    end

    // Storage array carries no reset; stale words are never read back.
    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem[wptr] <= dataIN;
        end
    end

    // Flags are registered from the next occupancy so they match the count exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            dataOUT <= '0;
            FULL_n  <= 1'b1;
            EMPTY_n <= 1'b0;
        end else begin
            if (wr_ok_c) begin
                wptr <= wptr + PTR_ONE;
            end
            if (rd_ok_c) begin
                rptr    <= rptr + PTR_ONE;
                dataOUT <= mem[rptr];
            end
            count   <= count_next;
            FULL_n  <= (count_next != CNT_FULL);
            EMPTY_n <= (count_next != '0);
        end
    end

endmodule

// File: tb/tb_fifo16_8bit.sv
// Scoreboard bench for fifo16_8bit: a model queue tracks stored words and every
// accepted read pops the expected byte, checked together with the flags each cycle.
module tb_fifo16_8bit;

    logic       clk;
    logic       rst;
    logic       en;
    logic       RD;
    logic       WR;
    logic [7:0] dataIN;
    logic [7:0] dataOUT;
    logic       FULL_n;
    logic       EMPTY_n;

    int unsigned n_checks;
    int unsigned n_pass;
    logic [7:0]  sb[$];
    logic [7:0]  exp_out;

    fifo16_8bit #(.WIDTH(8), .DEPTH(16), .AW(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .RD      (RD),
        .WR      (WR),
        .dataIN  (dataIN),
        .dataOUT (dataOUT),
        .FULL_n  (FULL_n),
        .EMPTY_n (EMPTY_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end else begin
            n_pass++;
        end
    endtask

    // One clock: drive request, update the model, compare just after the edge.
    task automatic cycle(input string tag, input logic e, input logic r, input logic w,
                         input logic [7:0] d);
        bit rd_ok;
        bit wr_ok;
        en     = e;
        RD     = r;
        WR     = w;
        dataIN = d;
        rd_ok  = e && r && (sb.size() > 0);
        wr_ok  = e && w && (sb.size() < 16);
        if (rd_ok) exp_out = sb.pop_front();
        if (wr_ok) sb.push_back(d);
        @(posedge clk);
        #1;
        check({tag, "_dout"}, 32'(dataOUT), 32'(exp_out));
        check({tag, "_full_n"}, 32'(FULL_n), 32'(sb.size() != 16));
        check({tag, "_empty_n"}, 32'(EMPTY_n), 32'(sb.size() != 0));
        en = 1'b1;
        RD = 1'b0;
        WR = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        exp_out  = 8'h00;
        rst      = 1'b0;
        en       = 1'b1;
        RD       = 1'b0;
        WR       = 1'b1;
        dataIN   = 8'h77;

        // Held in reset with write requested: nothing may be stored.
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", 32'(dataOUT), 32'h0);
        check("rst_empty_n", 32'(EMPTY_n), 32'h0);
        check("rst_full_n", 32'(FULL_n), 32'h1);
        WR  = 1'b0;
        rst = 1'b1;
        cycle("post_rst_idle", 1'b1, 1'b0, 1'b0, 8'h00);

        for (int i = 1; i <= 4; i++) cycle("basic_wr", 1'b1, 1'b0, 1'b1, 8'(i));
        for (int i = 0; i < 4; i++) cycle("basic_rd", 1'b1, 1'b1, 1'b0, 8'h00);
        check("basic_last", 32'(dataOUT), 32'h4);

        for (int i = 0; i < 16; i++) cycle("full_wr", 1'b1, 1'b0, 1'b1, 8'(8'h10 + i));
        check("full_flag", 32'(FULL_n), 32'h0);
        cycle("overflow_wr", 1'b1, 1'b0, 1'b1, 8'hAA);
        for (int i = 0; i < 16; i++) cycle("full_rd", 1'b1, 1'b1, 1'b0, 8'h00);
        check("full_last", 32'(dataOUT), 32'h1F);

        for (int i = 0; i < 3; i++) cycle("underflow_rd", 1'b1, 1'b1, 1'b0, 8'h00);
        cycle("empty_rdwr", 1'b1, 1'b1, 1'b1, 8'h30);
        for (int i = 1; i < 3; i++) cycle("sim_fill", 1'b1, 1'b0, 1'b1, 8'(8'h30 + i));
        for (int i = 3; i < 8; i++) cycle("sim_rdwr", 1'b1, 1'b1, 1'b1, 8'(8'h30 + i));
        check("sim_count_kept", 32'(EMPTY_n), 32'h1);
        for (int i = 0; i < 3; i++) cycle("sim_drain", 1'b1, 1'b1, 1'b0, 8'h00);

        for (int i = 0; i < 16; i++) cycle("fullrw_fill", 1'b1, 1'b0, 1'b1, 8'(8'h60 + i));
        cycle("full_rdwr", 1'b1, 1'b1, 1'b1, 8'hBB);
        for (int i = 0; i < 16; i++) cycle("fullrw_drain", 1'b1, 1'b1, 1'b0, 8'h00);

        for (int i = 0; i < 12; i++) cycle("wrap_wr12", 1'b1, 1'b0, 1'b1, 8'(8'h80 + i));
        for (int i = 0; i < 12; i++) cycle("wrap_rd12", 1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) cycle("wrap_wr8", 1'b1, 1'b0, 1'b1, 8'(8'hC0 + i));
        for (int i = 0; i < 8; i++) cycle("wrap_rd8", 1'b1, 1'b1, 1'b0, 8'h00);

        for (int i = 0; i < 4; i++) cycle("en_fill", 1'b1, 1'b0, 1'b1, 8'(8'hD0 + i));
        cycle("en_rd1", 1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) cycle("en_off", 1'b0, 1'b1, 1'b1, 8'hEE);
        for (int i = 0; i < 3; i++) cycle("en_drain", 1'b1, 1'b1, 1'b0, 8'h00);

        // Asynchronous reset between clock edges with data held.
        for (int i = 0; i < 6; i++) cycle("ar_fill", 1'b1, 1'b0, 1'b1, 8'(8'hF0 + i));
        cycle("ar_rd", 1'b1, 1'b1, 1'b0, 8'h00);
        #2;
        rst = 1'b0;
        #1;
        check("ar_empty_n", 32'(EMPTY_n), 32'h0);
        check("ar_full_n", 32'(FULL_n), 32'h1);
        check("ar_dout", 32'(dataOUT), 32'h0);
        sb.delete();
        exp_out = 8'h00;
        #1;
        rst = 1'b1;
        cycle("ar_wr55", 1'b1, 1'b0, 1'b1, 8'h55);
        cycle("ar_rd55", 1'b1, 1'b1, 1'b0, 8'h00);
        check("ar_val55", 32'(dataOUT), 32'h55);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
